quadra_poly_eval: RTL and testbench
===================================

// Module: quadra_poly_eval
// PURPOSE
//  Downstream of the squarer in the Quadratic Approximation Unit.
//  Combines LUT coefficients (a, b, c), the x2 fraction and its square
//  into y = a + b*x2 + c*x2^2 through a 3-stage valid/ready pipeline.
//  Its output is the unit's final approximation result.
// PARAMETERS
//  A_W   28  signed width of coefficient a; the sum grid is a's LSB
//  B_W   20  signed width of coefficient b
//  C_W   14  signed width of coefficient c
//  X2_W  16  unsigned width of x2 (Q0.X2_W)
//  SQ_W  16  unsigned width of sq (Q0.SQ_W, squarer output)
//  B_SH  16  arithmetic right shift of b*x2 onto the a grid
//  C_SH  16  arithmetic right shift of c*sq onto the a grid
//  Y_SH  4   arithmetic right shift of the sum before output narrowing
//  Y_W   24  signed output width
// PORTS
//  clk        in   1     single clock; all logic on rising edge
//  rst        in   1     reset, synchronous, active-high
//  in_valid   in   1     a/b/c/x2/sq are valid
//  in_ready   out  1     stage 1 can accept this cycle
//  a          in   A_W   coefficient a, signed
//  b          in   B_W   coefficient b, signed
//  c          in   C_W   coefficient c, signed
//  x2         in   X2_W  fraction x2, unsigned
//  sq         in   SQ_W  x2 squared from squarer, unsigned
//  out_valid  out  1     y is valid
//  out_ready  in   1     consumer accepts y
//  y          out  Y_W   approximation result, signed
//  ovf        out  1     y overflowed Y_W (qualified by out_valid)
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, y and ovf are 0. in_ready is
//    combinational and is 1 during the first cycle after reset.
//  - Transfer: one beat on valid&&ready. in_valid may not depend on
//    in_ready. Held data must stay stable while valid&&!ready.
//  - S1 registers a, pb=(b*x2)>>>B_SH, pc=(c*sq)>>>C_SH. x2 and sq are
//    zero-extended before multiplying; shifts truncate (floor).
//  - S2 registers sum = a+pb+pc at SUM_W=A_W+2 bits (sign-extended).
//  - S3 registers ys=sum>>>Y_SH, narrowed to Y_W, and ovf=1 when ys is
//    outside [-2^(Y_W-1), 2^(Y_W-1)-1].
//  - Latency: 3 cycles from input accept to out_valid with no stall.
//    Throughput is 1 per cycle.
//  - Stalls collapse bubbles. Stage k loads when it is empty or
//    stage k+1 loads/drains. in_ready = !v1 || s1 advances.
//    Capacity is 3 beats. Order is preserved. No drop or duplication.
//  - Simultaneous accept and drain on a full pipe: both occur and the
//    beat count is unchanged.
//  - rst mid-flight flushes all stages. In-flight beats are lost and
//    none is emitted afterwards.
// CONFIGURATION
//  QUADRA_SAT_EN defined: an overflowing y clamps to 2^(Y_W-1)-1 or
//    -2^(Y_W-1) by the sign of ys, and ovf is still reported.
//  QUADRA_SAT_EN undefined: y = ys[Y_W-1:0] (two's-complement wrap)
//    and ovf is still reported.
// STRUCTURE
//  - quadra.vh holds the typedefs a_t, b_t, c_t (reused x2_fxd_t,
//    sq_fxd_t), y_fxd_t, the SUM_W localparam and default widths/shifts.
//  - Sub-module quadra_pipe_reg: a parameterised-width valid/data
//    register with downstream-ready load enable, instantiated 3 times.
// TESTING
//  1 a=1<<20, b=0, c=0, x2=0, sq=0 -> y=0x010000, ovf=0, out_valid 3
//    cycles after accept.
//  2 a=0, b=1<<16, x2=0x8000, c=0 -> y=0x000800.
//  3 a=0, b=0, c=-4096, sq=0xFFFF -> y=0xFFFF00 (floor on negative).
//  4 a=2^27-1, b=2^19-1, x2=0xFFFF, c=0, sq=0 -> ovf=1. With
//    QUADRA_SAT_EN y=0x7FFFFF; without it y=0x807FFF.
//  5 4 back-to-back beats with out_ready=0 for 6 cycles -> in_ready
//    drops after 3 accepts, all 4 emerge in order, no duplicates.
//  6 rst pulsed with 2 beats in flight -> out_valid=0 next cycle and
//    no stale beat emerges. A new beat has latency 3.

Source files
------------

// File: rtl/quadra_poly_eval_pkg.sv
// Shared widths, shifts and fixed-point typedefs for the quadratic polynomial evaluator.
package quadra_poly_eval_pkg;
  localparam int DEF_A_W   = 28;
  localparam int DEF_B_W   = 20;
  localparam int DEF_C_W   = 14;
  localparam int DEF_X2_W  = 16;
  localparam int DEF_SQ_W  = 16;
  localparam int DEF_B_SH  = 16;
  localparam int DEF_C_SH  = 16;
  localparam int DEF_Y_SH  = 4;
  localparam int DEF_Y_W   = 24;
  localparam int DEF_SUM_W = DEF_A_W + 2;

  typedef logic signed [DEF_A_W-1:0]   a_t;
  typedef logic signed [DEF_B_W-1:0]   b_t;
  typedef logic signed [DEF_C_W-1:0]   c_t;
  typedef logic        [DEF_X2_W-1:0]  x2_fxd_t;
  typedef logic        [DEF_SQ_W-1:0]  sq_fxd_t;
  typedef logic signed [DEF_Y_W-1:0]   y_fxd_t;
  typedef logic signed [DEF_SUM_W-1:0] sum_t;
endpackage

// File: rtl/quadra_pipe_reg.sv
// One valid/data pipeline slot; it loads whenever it is empty or the downstream slot takes its beat.
module quadra_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_load,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_load  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Slot register: flushed by rst, otherwise reloaded on o_load (bubbles collapse).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end
endmodule

// File: rtl/quadra_poly_eval.sv
// y = a + b*x2 + c*x2^2 through a 3-stage valid/ready pipeline.
// Define QUADRA_SAT_EN to clamp overflowing results instead of wrapping them.
module quadra_poly_eval
  import quadra_poly_eval_pkg::*;
#(
  parameter int A_W  = quadra_poly_eval_pkg::DEF_A_W,
  parameter int B_W  = quadra_poly_eval_pkg::DEF_B_W,
  parameter int C_W  = quadra_poly_eval_pkg::DEF_C_W,
  parameter int X2_W = quadra_poly_eval_pkg::DEF_X2_W,
  parameter int SQ_W = quadra_poly_eval_pkg::DEF_SQ_W,
  parameter int B_SH = quadra_poly_eval_pkg::DEF_B_SH,
  parameter int C_SH = quadra_poly_eval_pkg::DEF_C_SH,
  parameter int Y_SH = quadra_poly_eval_pkg::DEF_Y_SH,
  parameter int Y_W  = quadra_poly_eval_pkg::DEF_Y_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [A_W-1:0]  a,
  input  logic signed [B_W-1:0]  b,
  input  logic signed [C_W-1:0]  c,
  input  logic        [X2_W-1:0] x2,
  input  logic        [SQ_W-1:0] sq,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic        [Y_W-1:0]  y,
  output logic                   ovf
);
  localparam int PB_FULL_W = B_W + X2_W + 1;
  localparam int PC_FULL_W = C_W + SQ_W + 1;
  localparam int PB_W      = PB_FULL_W - B_SH;
  localparam int PC_W      = PC_FULL_W - C_SH;
  localparam int S1_W      = A_W + PB_W + PC_W;
  localparam int SUM_W     = A_W + 2;
  localparam int YS_W      = SUM_W - Y_SH;
  localparam int S3_W      = Y_W + 1;

  logic                 w_ld1, w_ld2, w_ld3;
  logic                 w_v1, w_v2;
  logic [S1_W-1:0]      w_s1_in, w_s1_q;
  logic [SUM_W-1:0]     w_s2_in, w_s2_q;
  logic [S3_W-1:0]      w_s3_in, w_s3_q;
  logic [PB_FULL_W-1:0] w_pb_full;
  logic [PC_FULL_W-1:0] w_pc_full;
  logic [A_W-1:0]       w_a;
  logic [PB_W-1:0]      w_pb;
  logic [PC_W-1:0]      w_pc;
  logic [YS_W-1:0]      w_ys;
  logic [YS_W-Y_W:0]    w_ys_top;
  logic                 w_ovf;
  logic [Y_W-1:0]       w_y;

  // Low product bits do not depend on signedness, so sign/zero-extend by hand and multiply at full width.
  assign w_pb_full = {{(X2_W+1){b[B_W-1]}}, b} * {{B_W{1'b0}}, 1'b0, x2};
  assign w_pc_full = {{(SQ_W+1){c[C_W-1]}}, c} * {{C_W{1'b0}}, 1'b0, sq};
  assign w_s1_in   = {a, w_pb_full[PB_FULL_W-1:B_SH], w_pc_full[PC_FULL_W-1:C_SH]};

  assign w_a  = w_s1_q[S1_W-1 -: A_W];
  assign w_pb = w_s1_q[PB_W+PC_W-1 -: PB_W];
  assign w_pc = w_s1_q[PC_W-1:0];
  assign w_s2_in = {{(SUM_W-A_W){w_a[A_W-1]}}, w_a}
                 + {{(SUM_W-PB_W){w_pb[PB_W-1]}}, w_pb}
                 + {{(SUM_W-PC_W){w_pc[PC_W-1]}}, w_pc};

  // ys fits Y_W only when every bit from the Y_W sign position upward agrees.
  assign w_ys     = w_s2_q[SUM_W-1:Y_SH];
  assign w_ys_top = w_ys[YS_W-1:Y_W-1];
  assign w_ovf    = !((&w_ys_top) || !(|w_ys_top));

`ifdef QUADRA_SAT_EN
  // Clamp toward the sign of ys on overflow.
  always_comb begin
    w_y = w_ys[Y_W-1:0];
    if (w_ovf) begin
      w_y = w_ys[YS_W-1] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
    end else begin
      w_y = w_ys[Y_W-1:0];
    end
  end
`else
  assign w_y = w_ys[Y_W-1:0];
`endif

  assign w_s3_in  = {w_ovf, w_y};
  assign in_ready = w_ld1;
  assign y        = w_s3_q[Y_W-1:0];
  assign ovf      = w_s3_q[Y_W];

  quadra_pipe_reg #(.W(S1_W)) u_s1 (
    .clk(clk), .rst(rst), .i_valid(in_valid), .i_data(w_s1_in),
    .i_ready(w_ld2), .o_load(w_ld1), .o_valid(w_v1), .o_data(w_s1_q)
  );

  quadra_pipe_reg #(.W(SUM_W)) u_s2 (
    .clk(clk), .rst(rst), .i_valid(w_v1), .i_data(w_s2_in),
    .i_ready(w_ld3), .o_load(w_ld2), .o_valid(w_v2), .o_data(w_s2_q)
  );

  quadra_pipe_reg #(.W(S3_W)) u_s3 (
    .clk(clk), .rst(rst), .i_valid(w_v2), .i_data(w_s3_in),
    .i_ready(out_ready), .o_load(w_ld3), .o_valid(out_valid), .o_data(w_s3_q)
  );
endmodule

// File: tb/tb_quadra_poly_eval.sv
// Self-checking bench for quadra_poly_eval: directed cases, stall/fill, flush and a randomized run.
module tb_quadra_poly_eval;
  import quadra_poly_eval_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, out_valid, out_ready, ovf;
  a_t                   a;
  b_t                   b;
  c_t                   c;
  x2_fxd_t              x2;
  sq_fxd_t              sq;
  logic [DEF_Y_W-1:0]   y;
  int                   n_cmp = 0;
  int                   n_bad = 0;
  int                   n_out = 0;
  logic [DEF_Y_W:0]     exp_q[$];

  always #5 clk = ~clk;

  quadra_poly_eval dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .x2(x2), .sq(sq),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic with floor shifts, then range check and narrow.
  function automatic logic [DEF_Y_W:0] model(input a_t ma, input b_t mb, input c_t mc,
                                             input x2_fxd_t mx, input sq_fxd_t ms);
    longint pb, pc, ys, lim;
    logic [DEF_Y_W-1:0] yv;
    logic o;
    lim = longint'(1) <<< (DEF_Y_W - 1);
    pb  = (longint'(mb) * longint'(mx)) >>> DEF_B_SH;
    pc  = (longint'(mc) * longint'(ms)) >>> DEF_C_SH;
    ys  = (longint'(ma) + pb + pc) >>> DEF_Y_SH;
    o   = (ys >= lim) || (ys < -lim);
    yv  = ys[DEF_Y_W-1:0];
`ifdef QUADRA_SAT_EN
    if (o) begin
      yv = (ys < 0) ? {1'b1, {(DEF_Y_W-1){1'b0}}} : {1'b0, {(DEF_Y_W-1){1'b1}}};
    end
`endif
    return {o, yv};
  endfunction

  // Scoreboard: every output handshake must match the oldest accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          logic [DEF_Y_W:0] e;
          e = exp_q.pop_front();
          check_eq("sb_y", {40'd0, y}, {40'd0, e[DEF_Y_W-1:0]});
          check_eq("sb_ovf", {63'd0, ovf}, {63'd0, e[DEF_Y_W]});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c, x2, sq));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a = a_t'($urandom);
    if ($urandom_range(0, 1) == 1) a = a_t'(a >>> 6);
    b  = b_t'($urandom);
    c  = c_t'($urandom);
    x2 = x2_fxd_t'($urandom);
    sq = sq_fxd_t'((32'(x2) * 32'(x2)) >> 16);
  endtask

  task automatic directed(input string tag, input a_t ta, input b_t tb, input c_t tc,
                          input x2_fxd_t tx, input sq_fxd_t ts,
                          input logic [DEF_Y_W-1:0] ey, input logic eo);
    int lat;
    a = ta; b = tb; c = tc; x2 = tx; sq = ts;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'd3);
    check_eq({tag, "_y"}, {40'd0, y}, {40'd0, ey});
    check_eq({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, base;
    logic acc, pending;
    logic [DEF_Y_W-1:0] ey4;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; x2 = '0; sq = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_y", {40'd0, y}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();

    directed("t1_a_only", a_t'(28'h0100000), b_t'(20'h0), c_t'(14'h0), x2_fxd_t'(16'h0),
             sq_fxd_t'(16'h0), 24'h010000, 1'b0);
    directed("t2_b_term", a_t'(28'h0), b_t'(20'h10000), c_t'(14'h0), x2_fxd_t'(16'h8000),
             sq_fxd_t'(16'h0), 24'h000800, 1'b0);
    directed("t3_c_floor", a_t'(28'h0), b_t'(20'h0), c_t'(14'h3000), x2_fxd_t'(16'h0),
             sq_fxd_t'(16'hFFFF), 24'hFFFF00, 1'b0);
`ifdef QUADRA_SAT_EN
    ey4 = 24'h7FFFFF;
`else
    ey4 = 24'h807FFF;
`endif
    directed("t4_ovf", a_t'(28'h7FFFFFF), b_t'(20'h7FFFF), c_t'(14'h0), x2_fxd_t'(16'hFFFF),
             sq_fxd_t'(16'h0), ey4, 1'b1);

    // Fill with the consumer stalled: three beats fit, the fourth waits.
    base = n_out;
    out_ready = 1'b0;
    k = 0;
    rand_beat();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        k++;
        if (k < 4) rand_beat(); else in_valid = 1'b0;
      end
    end
    check_eq("stall_accepts", 64'(k), 64'd3);
    @(negedge clk);
    check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("stall_out_valid", {63'd0, out_valid}, 64'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !(k == 4 && n_out - base == 4); i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        k++;
        in_valid = 1'b0;
      end
    end
    check_eq("stall_out_count", 64'(n_out - base), 64'd4);
    check_eq("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush two in-flight beats with a one-cycle reset.
    rand_beat();
    in_valid = 1'b1;
    tick();
    rand_beat();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    base = n_out;
    repeat (8) tick();
    check_eq("flush_no_stale", 64'(n_out - base), 64'd0);
    directed("post_rst", a_t'(28'h0100000), b_t'(20'h0), c_t'(14'h0), x2_fxd_t'(16'h0),
             sq_fxd_t'(16'h0), 24'h010000, 1'b0);

    // Randomized traffic with random backpressure; held beats stay stable until taken.
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) rand_beat();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      pending = in_valid && !acc;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    check_eq("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
